// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers.
// Results are computed when an operation is accepted, held pending for the busy period, then committed to HI/LO.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] HILOout
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [31:0]        hi_reg, lo_reg;
    logic [31:0]        pend_hi_reg, pend_lo_reg;
    logic               pend_we_reg;

    // Products: full 64-bit signed and unsigned
    logic signed [63:0] a_sext, b_sext, prod_s;
    logic [63:0]        prod_u, prod;

    assign a_sext = {{32{A[31]}}, A};
    assign b_sext = {{32{B[31]}}, B};
    assign prod_s = a_sext * b_sext;
    assign prod_u = {32'b0, A} * {32'b0, B};
    assign prod   = (op == OP_MULT) ? prod_s : prod_u;

    // One shared unsigned divider; signed division works on magnitudes and fixes signs afterwards.
    // The magnitude of 0x80000000 is 2^31 as unsigned, so the overflow case falls out naturally.
    logic        is_sdiv, q_neg, r_neg;
    logic [31:0] dvd, dvs, dvs_safe, q_mag, r_mag, quot, rem;

    assign is_sdiv  = (op == OP_DIV);
    assign dvd      = (is_sdiv && A[31]) ? -A : A;
    assign dvs      = (is_sdiv && B[31]) ? -B : B;
    assign dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    assign q_mag    = dvd / dvs_safe;
    assign r_mag    = dvd % dvs_safe;
    assign q_neg    = is_sdiv && (A[31] ^ B[31]);
    assign r_neg    = is_sdiv && A[31];
    assign quot     = q_neg ? -q_mag : q_mag;
    assign rem      = r_neg ? -r_mag : r_mag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            pend_hi_reg <= '0;
            pend_lo_reg <= '0;
            pend_we_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!req) begin
                        if (start && (op == OP_MULT || op == OP_MULTU)) begin
                            pend_hi_reg <= prod[63:32];
                            pend_lo_reg <= prod[31:0];
                            pend_we_reg <= 1'b1;
                            cnt_reg     <= CNT_W'(MULT_CYCLES);
                            state_reg   <= MUL;
                        end else if (start && (op == OP_DIV || op == OP_DIVU)) begin
                            pend_hi_reg <= rem;
                            pend_lo_reg <= quot;
                            pend_we_reg <= (B != 32'd0);
                            cnt_reg     <= CNT_W'(DIV_CYCLES);
                            state_reg   <= DIV;
                        end else if (op == OP_MTHI) begin
                            hi_reg <= A;
                        end else if (op == OP_MTLO) begin
                            lo_reg <= A;
                        end
                    end
                end
                default: begin
                    // In-flight work ignores req: it is already architecturally committed
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        if (pend_we_reg) begin
                            hi_reg <= pend_hi_reg;
                            lo_reg <= pend_lo_reg;
                        end
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy    = (state_reg != IDLE);
    assign HI      = hi_reg;
    assign LO      = lo_reg;
    assign HILOout = (op == OP_MFHI) ? hi_reg :
                     (op == OP_MFLO) ? lo_reg : 32'd0;
endmodule

// File: tb/tb_mdu.sv
// Randomized scoreboard bench for mdu: stimulus pushes expected HI/LO and busy length,
// a monitor pops and compares each time busy drops.
module tb_mdu;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] A = '0, B = '0;
    logic        busy;
    logic [31:0] HI, LO, HILOout;

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .HILOout(HILOout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    bit          abort_ok = 1'b0;
    logic [31:0] model_hi = '0, model_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural meaning of each op
    task automatic ref_md(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eh, output logic [31:0] el, output bit we);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, pu, qu, ru;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        we = 1'b1;
        eh = '0;
        el = '0;
        case (o)
            4'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            4'd2: begin pu = ua * ub; eh = pu[63:32]; el = pu[31:0]; end
            4'd3: begin
                if (b == 0) we = 1'b0;
                else begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
            end
            default: begin
                if (b == 0) we = 1'b0;
                else begin qu = ua / ub; ru = ua % ub; eh = ru[31:0]; el = qu[31:0]; end
            end
        endcase
    endtask

    task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic r, input bit mid_req);
        logic [31:0] eh, el, exp_out;
        bit          we;
        bit          multi;
        int          k;
        multi = (o >= 4'd1 && o <= 4'd4);
        @(negedge clk);
        op = o; A = a; B = b; req = r; start = multi;
        $display("txn op=%0d A=%h B=%h req=%0b", o, a, b, r);
        #1;
        exp_out = (o == 4'd5) ? model_hi : (o == 4'd6) ? model_lo : 32'd0;
        chk("HILOout", HILOout, exp_out);
        if (multi && !r) begin
            ref_md(o, a, b, eh, el, we);
            if (we) begin model_hi = eh; model_lo = el; end
            sb_q.push_back('{hi: model_hi, lo: model_lo, n: (o <= 4'd2) ? MC : DC});
        end else if (!r && o == 4'd7) begin
            model_hi = a;
        end else if (!r && o == 4'd8) begin
            model_lo = a;
        end
        @(negedge clk);
        start = 1'b0; req = 1'b0; op = 4'd0;
        if (multi && !r) begin
            k = 0;
            while (busy && k < 40) begin
                req = mid_req && (k == 1);
                @(negedge clk);
                k++;
            end
            req = 1'b0;
            chk("busy_done", busy, 0);
        end else begin
            chk("no_busy", busy, 0);
            chk("HI_imm", HI, model_hi);
            chk("LO_imm", LO, model_lo);
        end
    endtask

    // Monitor: each falling busy is a completion; compare with the oldest expectation
    initial begin : monitor
        int   run;
        logic prev;
        exp_t e;
        run = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (busy) begin
                run++;
            end else if (prev) begin
                if (sb_q.size() == 0) begin
                    chk("no_unexpected_commit", abort_ok, 1);
                    abort_ok = 1'b0;
                end else begin
                    e = sb_q.pop_front();
                    chk("busy_len", run, e.n);
                    chk("HI_commit", HI, e.hi);
                    chk("LO_commit", LO, e.lo);
                end
                run = 0;
            end
            prev = busy;
        end
    end

    initial begin : stimulus
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        logic        rr;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_HI", HI, 0);
        chk("rst_LO", LO, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;

        do_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
        chk("mult_HI", HI, 32'hFFFFFFFF);
        chk("mult_LO", LO, 32'hFFFFFFFA);
        do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("multu_HI", HI, 32'hFFFFFFFE);
        chk("multu_LO", LO, 32'h00000001);
        do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        chk("div_HI", HI, 32'hFFFFFFFF);
        chk("div_LO", LO, 32'hFFFFFFFD);
        do_op(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        chk("divz_HI", HI, 32'hFFFFFFFF);
        chk("divz_LO", LO, 32'hFFFFFFFD);
        do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("ovf_HI", HI, 32'h0);
        chk("ovf_LO", LO, 32'h80000000);
        do_op(4'd1, 32'd9, 32'd9, 1'b1, 1'b0);
        do_op(4'd8, 32'h1234, 32'd0, 1'b1, 1'b0);
        do_op(4'd1, 32'd1000, 32'hFFFFFFF0, 1'b0, 1'b1);
        chk("midreq_LO", LO, 32'hFFFFC180);
        do_op(4'd7, 32'hABCD, 32'd0, 1'b0, 1'b0);
        do_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        do_op(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            ro = 4'($urandom_range(0, 10));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 20));
            rr = ($urandom_range(0, 5) == 0);
            do_op(ro, ra, rb, rr, ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a DIV: abort with no late commit
        do_op(4'd7, 32'h5555AAAA, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        op = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
        $display("txn op=3 A=%h B=%h req=0 (reset mid-operation)", A, B);
        @(negedge clk);
        start = 1'b0; op = 4'd0;
        @(posedge clk);
        @(posedge clk);
        #2;
        abort_ok = 1'b1;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_HI", HI, 0);
        chk("abort_LO", LO, 0);
        model_hi = '0;
        model_lo = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("post_abort_busy", busy, 0);
        chk("post_abort_HI", HI, 0);
        chk("post_abort_LO", LO, 0);

        do_op(4'd2, 32'd6, 32'd7, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
